// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit next to the execute ALU.
// Multiplies by shift-add, divides by restoring subtraction, one step per
// cycle, on operand magnitudes with a sign fix-up on the last step.
// Optional build macro MULDIV_FAST_MUL_EN: MUL variants use a single-cycle
// combinational multiplier; division always stays iterative.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start_i; trivial cases complete straight to DONE
//   MUL    | one shift-add step per cycle, cnt_q counts XLEN-1 down to 0
//   DIV    | one restoring-subtract step per cycle, same counter
//   DONE   | result valid for one cycle (done_o = wreg_o = 1)

module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       reg1_i,
    input  logic [XLEN-1:0]       reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*XLEN-1:0]     acc_q;
    logic [XLEN-1:0]       mb_q;
    logic [2:0]            op_q;
    logic                  neg_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic [XLEN-1:0]       wdata_q;
    logic                  done_q;

    logic                  a_neg, b_neg, res_neg;
    logic [XLEN-1:0]       mag_a, mag_b;
    logic                  div_zero, div_ovf, mul_zero, special;
    logic [XLEN-1:0]       special_res;
    logic [XLEN:0]         mul_sum, div_shift, div_sub;
    logic                  div_ge;
    logic [2*XLEN-1:0]     mul_acc_d, div_acc_d, mul_fix;
    logic [XLEN-1:0]       mul_res, div_raw, div_res;

    // Operand magnitudes, result sign and the cases that skip iteration.
    always_comb begin
        // MUL low half is identical signed or unsigned, so treat it unsigned.
        a_neg    = reg1_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_MULHSU) |
                                     (op_i == OP_DIV)  | (op_i == OP_REM));
        b_neg    = reg2_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_DIV) |
                                     (op_i == OP_REM));
        mag_a    = a_neg ? -reg1_i : reg1_i;
        mag_b    = b_neg ? -reg2_i : reg2_i;
        // Remainder takes the dividend's sign; everything else the XOR.
        res_neg  = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = op_i[2] & (reg2_i == '0);
        div_ovf  = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                   (reg1_i == MIN_NEG) & (reg2_i == '1);
        mul_zero = ~op_i[2] & ((reg1_i == '0) | (reg2_i == '0));
        special  = div_zero | div_ovf | mul_zero;
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? reg1_i : '1;
        else if (div_ovf)
            special_res = op_i[1] ? '0 : reg1_i;
    end

    // One iteration step of each algorithm plus the signed final result.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mb_q};
        div_sub   = div_shift - {1'b0, mb_q};
        div_acc_d = {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};
        mul_fix   = neg_q ? -mul_acc_d : mul_acc_d;
        mul_res   = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
        div_raw   = op_q[1] ? div_acc_d[2*XLEN-1:XLEN] : div_acc_d[XLEN-1:0];
        div_res   = neg_q ? -div_raw : div_raw;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;

    // Single-cycle multiplier on the magnitudes, same sign fix-up.
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        fast_fix  = res_neg ? -fast_prod : fast_prod;
        fast_res  = (op_i == OP_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end
`endif

    // Sequencing FSM; all outputs except stall are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mb_q    <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            wd_q    <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q  <= op_i;
                        wd_q  <= wd_i;
                        neg_q <= res_neg;
                        mb_q  <= mag_b;
                        acc_q <= {{XLEN{1'b0}}, mag_a};
                        cnt_q <= CNT_W'(XLEN - 1);
                        if (special) begin
                            wdata_q <= special_res;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!op_i[2]) begin
                            wdata_q <= fast_res;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            state_q <= op_i[2] ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= (state_q == S_MUL) ? mul_acc_d : div_acc_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            wdata_q <= (state_q == S_MUL) ? mul_res : div_res;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall_req_o = ((state_q == S_IDLE) & start_i) |
                         (state_q == S_MUL) | (state_q == S_DIV);
    assign done_o  = done_q;
    assign wreg_o  = done_q;
    assign wdata_o = wdata_q;
    assign wd_o    = wd_q;

endmodule
